accel_spi_reader: RTL and testbench



---
 rtl/accel_spi_reader.sv | 250 +++++++++++++++++++++++++
 tb/tb_accel_spi_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// -----------------------------------------------------------------------------
// accel_spi_reader
// SPI master (mode 3, MSB first) that configures the ADXL345 accelerometer and
// then reads the X/Y sample registers at a fixed rate. Raw 16-bit samples are
// arithmetic-shifted right by SHIFT and saturated to signed 8 bits.
//
// Ports:
//   pixel_clk     in   1  clock (the only clock)
//   rst_n         in   1  synchronous active-low reset
//   spi_cs_n      out  1  chip select, active low
//   spi_sclk      out  1  SPI clock, idles high
//   spi_mosi      out  1  master out
//   spi_miso      in   1  master in
//   accel_data_x  out  8  signed X sample
//   accel_data_y  out  8  signed Y sample
//   accel_data_z  out  8  signed Z sample (only with ACCEL_SPI_Z_EN)
//   data_valid    out  1  one-cycle pulse when the samples update
//   init_done     out  1  sticky, set when both configuration writes are done
//
// Build option: define ACCEL_SPI_Z_EN to also read and output the Z axis.
// -----------------------------------------------------------------------------
module accel_spi_reader #(
  parameter int unsigned CLK_DIV       = 18,
  parameter int unsigned SAMPLE_PERIOD = 360000,
  parameter int unsigned INIT_DELAY    = 72000,
  parameter int unsigned SHIFT         = 2
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] accel_data_x,
  output logic [7:0] accel_data_y,
`ifdef ACCEL_SPI_Z_EN
  output logic [7:0] accel_data_z,
`endif
  output logic       data_valid,
  output logic       init_done
);

`ifdef ACCEL_SPI_Z_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 4;
`endif
  localparam int RX_W      = 8 * NBYTES;
  localparam int READ_BITS = 8 + RX_W;
  localparam int CFG_BITS  = 16;
  localparam int BIT_W     = $clog2(READ_BITS);
  localparam int TMR_W     = $clog2(CLK_DIV);
  localparam int CNT_MAX   = (INIT_DELAY > SAMPLE_PERIOD) ? INIT_DELAY : SAMPLE_PERIOD;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_WAIT_PWR, S_CFG_FMT, S_CFG_PWR, S_IDLE, S_READ, S_UPDATE
  } state_e;

  // Sub-phases of one SPI frame; each lasts CLK_DIV cycles.
  typedef enum logic [2:0] {
    PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD, PH_GAP
  } phase_e;

  state_e             state_q;
  phase_e             phase_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [BIT_W-1:0]   bit_q;
  logic [15:0]        tx_q;
  logic [RX_W-1:0]    rx_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q;
  logic               cs_n_q, sclk_q, mosi_q, valid_q, init_q;
  logic [7:0]         x_q, y_q;
`ifdef ACCEL_SPI_Z_EN
  logic [7:0]         z_q;
`endif

  logic in_frame, tmr_end, last_bit, frame_done, period_end;

  assign in_frame   = (state_q == S_CFG_FMT) || (state_q == S_CFG_PWR) || (state_q == S_READ);
  assign tmr_end    = (tmr_q == TMR_W'(CLK_DIV - 1));
  assign last_bit   = (state_q == S_READ) ? (bit_q == BIT_W'(READ_BITS - 1))
                                          : (bit_q == BIT_W'(CFG_BITS - 1));
  assign frame_done = (phase_q == PH_GAP) && tmr_end;
  assign period_end = (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
  // Sample counter free-runs through IDLE/READ/UPDATE so read starts stay on a fixed grid.
  assign cnt_d      = period_end ? '0 : cnt_q + 1'b1;

  // Receive order is X0, X1, Y0, Y1 (, Z0, Z1); registers are little-endian.
  logic [15:0] raw_x, raw_y;
  assign raw_x = {rx_q[RX_W-9 -: 8],  rx_q[RX_W-1 -: 8]};
  assign raw_y = {rx_q[RX_W-25 -: 8], rx_q[RX_W-17 -: 8]};
`ifdef ACCEL_SPI_Z_EN
  logic [15:0] raw_z;
  assign raw_z = {rx_q[RX_W-41 -: 8], rx_q[RX_W-33 -: 8]};
`endif

  function automatic logic [7:0] sat8(input logic [15:0] raw);
    logic signed [15:0] s;
    s = $signed(raw) >>> SHIFT;
    if (s > 16'sd127)       return 8'h7F;
    else if (s < -16'sd128) return 8'h80;
    else                    return s[7:0];
  endfunction

  // NOTE: all state uses non-blocking assignments; where two assignments to the
  // same register occur in one cycle below, the later one (frame start) wins.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT_PWR;
      phase_q <= PH_SETUP;
      tmr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
`ifdef ACCEL_SPI_Z_EN
      z_q     <= '0;
`endif
    end else begin
      valid_q <= 1'b0;

      // Frame engine: walks SETUP -> (LOW/HIGH per bit) -> HOLD -> GAP.
      if (in_frame) begin
        tmr_q <= tmr_end ? '0 : tmr_q + 1'b1;
        if (tmr_end) begin
          unique case (phase_q)
            PH_SETUP: begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_q[15];
              tx_q    <= {tx_q[14:0], 1'b0};
              phase_q <= PH_LOW;
            end
            PH_LOW: begin
              sclk_q <= 1'b1;
              // Only data bits of a read are captured; the command byte is ignored.
              if (state_q == S_READ && bit_q >= BIT_W'(8))
                rx_q <= {rx_q[RX_W-2:0], spi_miso};
              phase_q <= last_bit ? PH_HOLD : PH_HIGH;
            end
            PH_HIGH: begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_q[15];
              tx_q    <= {tx_q[14:0], 1'b0};
              bit_q   <= bit_q + 1'b1;
              phase_q <= PH_LOW;
            end
            PH_HOLD: begin
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              phase_q <= PH_GAP;
              if (state_q == S_CFG_PWR) init_q <= 1'b1;
            end
            PH_GAP: ;
          endcase
        end
      end

      unique case (state_q)
        S_WAIT_PWR: begin
          if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
            cnt_q   <= '0;
            state_q <= S_CFG_FMT;
            cs_n_q  <= 1'b0;
            phase_q <= PH_SETUP;
            tmr_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 16'h3100;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CFG_FMT: begin
          if (frame_done) begin
            state_q <= S_CFG_PWR;
            cs_n_q  <= 1'b0;
            phase_q <= PH_SETUP;
            tmr_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 16'h2D08;
          end
        end
        S_CFG_PWR: begin
          if (frame_done) state_q <= S_IDLE;
        end
        S_IDLE: begin
          cnt_q <= cnt_d;
          if (period_end) begin
            state_q <= S_READ;
            cs_n_q  <= 1'b0;
            phase_q <= PH_SETUP;
            tmr_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 16'hF200;
          end
        end
        S_READ: begin
          cnt_q <= cnt_d;
          // Remember a period boundary that passed while the frame was running.
          if (period_end) pend_q <= 1'b1;
          if (frame_done) begin
            state_q <= S_UPDATE;
            valid_q <= 1'b1;
            x_q     <= sat8(raw_x);
            y_q     <= sat8(raw_y);
`ifdef ACCEL_SPI_Z_EN
            z_q     <= sat8(raw_z);
`endif
          end
        end
        S_UPDATE: begin
          if (pend_q || period_end) begin
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_READ;
            cs_n_q  <= 1'b0;
            phase_q <= PH_SETUP;
            tmr_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 16'hF200;
          end else begin
            cnt_q   <= cnt_d;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign spi_cs_n     = cs_n_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign accel_data_x = x_q;
  assign accel_data_y = y_q;
`ifdef ACCEL_SPI_Z_EN
  assign accel_data_z = z_q;
`endif
  assign data_valid   = valid_q;
  assign init_done    = init_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// -----------------------------------------------------------------------------
// tb_accel_spi_reader
// Bench for accel_spi_reader. A behavioural ADXL345 slave decodes each frame
// from the pins, returns randomized (plus a few fixed) sample words on MISO and
// predicts the converted outputs; one negedge process compares every cycle.
// -----------------------------------------------------------------------------
module tb_accel_spi_reader;

  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 500;
  localparam int INIT_DELAY    = 10;
  localparam int SHIFT         = 2;
`ifdef ACCEL_SPI_Z_EN
  localparam int RB = 56;
`else
  localparam int RB = 40;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [7:0] accel_data_x, accel_data_y;
`ifdef ACCEL_SPI_Z_EN
  logic [7:0] accel_data_z;
`endif
  logic       data_valid, init_done;

  always #5 clk = ~clk;

  accel_spi_reader #(
    .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .INIT_DELAY(INIT_DELAY), .SHIFT(SHIFT)
  ) dut (
    .pixel_clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .accel_data_x(accel_data_x), .accel_data_y(accel_data_y),
`ifdef ACCEL_SPI_Z_EN
    .accel_data_z(accel_data_z),
`endif
    .data_valid(data_valid), .init_done(init_done)
  );

  typedef struct {
    logic [15:0] x, y, z;
    int          tag;
  } rd_t;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec rule: signed 16-bit, arithmetic shift right, clamp to [-128, 127].
  function automatic logic [7:0] conv(input logic [15:0] raw);
    int s;
    s = int'($signed(raw));
    s = s >>> SHIFT;
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
    return 8'(s);
  endfunction

  // Model state shared with the stimulus process.
  rd_t         pend[$];
  rd_t         cur, r;
  logic [7:0]  held_x = 0, held_y = 0, held_z = 0;
  logic        exp_init = 0;
  logic        rst_prev = 0, prev_cs = 1, prev_sclk = 1;
  logic [55:0] mosi_bits;
  logic [47:0] stream;
  logic [15:0] bnd [4] = '{16'h01FC, 16'h0200, 16'hFE00, 16'hFDFC};
  int since_rel = 0, last_evt = 0, last_rise = 0, last_read_fall = 0;
  int frame_idx = 0, read_idx = 0, rd_total = 0, valid_total = 0;
  int nbits = 0, nfalls = 0, pend_age = 0;
  logic in_frame = 0;

  // Slave model + per-cycle compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_prev) begin
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 1);
        check("rst_mosi", spi_mosi, 0);
        check("rst_x", accel_data_x, 0);
        check("rst_y", accel_data_y, 0);
`ifdef ACCEL_SPI_Z_EN
        check("rst_z", accel_data_z, 0);
`endif
        check("rst_valid", data_valid, 0);
        check("rst_init", init_done, 0);
        frame_idx = 0; read_idx = 0; in_frame = 0; pend.delete(); pend_age = 0;
        held_x = 0; held_y = 0; held_z = 0; exp_init = 0;
        since_rel = 0; prev_cs = 1; prev_sclk = 1;
      end else begin
        since_rel++;
        if (prev_cs && !spi_cs_n) begin
          if (frame_idx == 0) check("first_cs_fall_cycle", since_rel, INIT_DELAY);
          else check("cs_high_gap", (since_rel - last_rise) >= CLK_DIV, 1);
          if (frame_idx >= 2) begin
            if (read_idx == 0)
              check("first_read_delay", (since_rel - last_rise >= SAMPLE_PERIOD) &&
                    (since_rel - last_rise <= SAMPLE_PERIOD + 2*CLK_DIV + 1), 1);
            else
              check("read_period", since_rel - last_read_fall, SAMPLE_PERIOD);
            last_read_fall = since_rel;
            cur.tag = rd_total;
            cur.x = 16'($urandom); cur.y = 16'($urandom); cur.z = 16'($urandom);
            if (rd_total == 0) begin cur.x = 16'h0104; cur.y = 16'hFF00; cur.z = 16'hFFFC; end
            else if (rd_total == 1) begin cur.x = 16'h7FFF; cur.y = 16'h8000; end
            else if (rd_total < 6) cur.x = bnd[rd_total-2];
            stream = {cur.x[7:0], cur.x[15:8], cur.y[7:0], cur.y[15:8], cur.z[7:0], cur.z[15:8]};
            rd_total++;
          end
          in_frame = 1; nbits = 0; nfalls = 0; mosi_bits = '0; last_evt = since_rel;
        end else if (in_frame && !spi_cs_n) begin
          if (spi_sclk != prev_sclk) begin
            check("sclk_half_period", since_rel - last_evt, CLK_DIV);
            last_evt = since_rel;
            if (!spi_sclk) begin
              if (frame_idx >= 2 && nfalls >= 8) spi_miso = stream[47-(nfalls-8)];
              else spi_miso = 1'($urandom);
              nfalls++;
            end else begin
              mosi_bits = {mosi_bits[54:0], spi_mosi};
              nbits++;
            end
          end
        end else if (in_frame && spi_cs_n) begin
          check("cs_hold_after_last_bit", since_rel - last_evt, CLK_DIV);
          if (frame_idx == 0) begin
            check("cfg_fmt_bits", nbits, 16);
            check("cfg_fmt_mosi", mosi_bits[15:0], 16'h3100);
          end else if (frame_idx == 1) begin
            check("cfg_pwr_bits", nbits, 16);
            check("cfg_pwr_mosi", mosi_bits[15:0], 16'h2D08);
            exp_init = 1;
          end else begin
            check("read_frame_bits", nbits, RB);
            check("read_cmd_byte", mosi_bits[RB-1 -: 8], 8'hF2);
            check("read_mosi_zero", mosi_bits[RB-9:0], 0);
            pend.push_back(cur);
            read_idx++;
          end
          in_frame = 0; last_rise = since_rel; frame_idx++;
          spi_miso = 1'($urandom);
        end
        if (spi_cs_n) check("sclk_idle_high", spi_sclk, 1);
        check("init_done", init_done, exp_init);
        if (data_valid) begin
          check("valid_has_frame", pend.size(), 1);
          if (pend.size() > 0) begin
            r = pend.pop_front();
            held_x = conv(r.x); held_y = conv(r.y); held_z = conv(r.z);
            if (r.tag == 0) begin
              check("lit_x_260", accel_data_x, 8'h41);
              check("lit_y_m256", accel_data_y, 8'hC0);
`ifdef ACCEL_SPI_Z_EN
              check("lit_z_m4", accel_data_z, 8'hFF);
`endif
            end else if (r.tag == 1) begin
              check("lit_x_sat_pos", accel_data_x, 8'h7F);
              check("lit_y_sat_neg", accel_data_y, 8'h80);
            end
          end
          valid_total++;
        end
        check("accel_x", accel_data_x, held_x);
        check("accel_y", accel_data_y, held_y);
`ifdef ACCEL_SPI_Z_EN
        check("accel_z", accel_data_z, held_z);
`endif
        if (pend.size() > 0) begin
          pend_age++;
          if (pend_age == 3*CLK_DIV + 4) begin
            n_checks++; n_fails++;
            $display("FAIL valid_latency: no data_valid %0d cycles after read frame", pend_age);
          end
        end else begin
          pend_age = 0;
        end
        prev_cs = spi_cs_n; prev_sclk = spi_sclk;
      end
      rst_prev = rst_n;
    end
  end

  task automatic wait_valids(input int n, input int budget, input string what);
    int c;
    c = 0;
    while (valid_total < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    n_checks++;
    if (valid_total < n) begin
      n_fails++;
      $display("FAIL %s: %0d data_valid pulses seen, expected %0d", what, valid_total, n);
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_valids(4, 6000, "periodic_reads");

    // Abort a read after 12 bits.
    c = 0;
    while (!(in_frame && frame_idx >= 2 && nbits >= 12) && c < 2000) begin
      @(posedge clk);
      c++;
    end
    n_checks++;
    if (!(in_frame && frame_idx >= 2 && nbits >= 12)) begin
      n_fails++;
      $display("FAIL mid_read_wait: read frame with 12 bits not reached");
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_valids(6, 4000, "reads_after_reinit");
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
